// File: rtl/if_align_buffer_pkg.sv
// Shared fetch-path definitions.
//   ADDR_WIDTH : default PC width
//   START_PC   : architectural reset vector of the core
//   RVC_OP32   : low two bits marking a 32-bit (non-compressed) instruction
package if_align_buffer_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam logic [31:0] START_PC   = 32'h8000_0000;
  localparam logic [1:0]  RVC_OP32   = 2'b11;

endpackage

// File: rtl/if_hw_queue.sv
// Halfword FIFO used by the fetch alignment buffer.
//   clk, rst_n          : clock, synchronous active-low reset (clears storage too)
//   flush               : empty the queue (pointers and count to 0)
//   push_num            : halfwords to push this cycle (0..2)
//   push_hw0, push_hw1  : first / second halfword to push
//   pop_num             : halfwords to pop this cycle (0..2)
//   count               : halfwords currently held
//   head_hw0, head_hw1  : halfwords at head and head+1
module if_hw_queue #(
  parameter int unsigned BUF_HW = 4,
  localparam int unsigned PTR_W = $clog2(BUF_HW),
  localparam int unsigned CNT_W = $clog2(BUF_HW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [1:0]       push_num,
  input  logic [15:0]      push_hw0,
  input  logic [15:0]      push_hw1,
  input  logic [1:0]       pop_num,
  output logic [CNT_W-1:0] count,
  output logic [15:0]      head_hw0,
  output logic [15:0]      head_hw1
);

  logic [15:0]      mem_q [BUF_HW];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  // Pointer advance modulo BUF_HW; n never exceeds 2 and BUF_HW >= 2.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
    int unsigned s;
    s = int'(p) + int'(n);
    if (s >= BUF_HW) s = s - BUF_HW;
    return PTR_W'(s);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_HW; i++) mem_q[i] <= 16'h0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_num != 2'd0) mem_q[tail_q] <= push_hw0;
      if (push_num == 2'd2) mem_q[ptr_add(tail_q, 2'd1)] <= push_hw1;
      tail_q  <= ptr_add(tail_q, push_num);
      head_q  <= ptr_add(head_q, pop_num);
      count_q <= count_q + CNT_W'(push_num) - CNT_W'(pop_num);
    end
  end

  assign count    = count_q;
  assign head_hw0 = mem_q[head_q];
  assign head_hw1 = mem_q[ptr_add(head_q, 2'd1)];

endmodule

// File: rtl/if_align_buffer.sv
// Fetch alignment buffer: turns a stream of 32-bit fetch words into aligned
// 16/32-bit instructions with their PCs.
//   clk, rst_n             : clock, synchronous active-low reset
//   flush                  : redirect; drop everything buffered
//   fetch_valid/ready      : fetch word handshake (ready depends on registered state only)
//   fetch_pc, fetch_word   : word address (bit 0 = 0) and data
//   inst_valid/ready       : instruction handshake towards decode
//   inst, inst_pc          : aligned instruction (16-bit zero-extended) and its PC
//   inst_16bit             : instruction is compressed
module if_align_buffer
  import if_align_buffer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = if_align_buffer_pkg::ADDR_WIDTH,
  parameter int unsigned BUF_HW     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic [ADDR_WIDTH-1:0] fetch_pc,
  input  logic [31:0]           fetch_word,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_16bit
);

  localparam int unsigned CNT_W = $clog2(BUF_HW + 1);

  logic [CNT_W-1:0]      count;
  logic [15:0]           head_hw0, head_hw1;
  logic [1:0]            push_num, pop_num;
  logic [15:0]           push_hw0;
  logic                  accept, pop, head_is32, reload;
  logic [ADDR_WIDTH-1:0] head_pc_q, tail_pc_q;

  // Room for a full word (two halfwords) is required before accepting.
  assign fetch_ready = (count <= CNT_W'(BUF_HW - 2));
  assign accept      = fetch_valid & fetch_ready & ~flush;
  assign push_num    = !accept ? 2'd0 : (fetch_pc[1] ? 2'd1 : 2'd2);
  assign push_hw0    = fetch_pc[1] ? fetch_word[31:16] : fetch_word[15:0];

  assign head_is32  = (head_hw0[1:0] == RVC_OP32);
  // A lone upper half of a straddling 32-bit instruction is not issuable.
  assign inst_valid = ((count >= CNT_W'(1)) && !head_is32) || (count >= CNT_W'(2));
  assign inst_16bit = inst_valid & ~head_is32;
  assign inst       = head_is32 ? {head_hw1, head_hw0} : {16'h0, head_hw0};
  assign inst_pc    = head_pc_q;

  assign pop     = inst_valid & inst_ready & ~flush;
  assign pop_num = !pop ? 2'd0 : (head_is32 ? 2'd2 : 2'd1);

  // Buffer is (or becomes) empty this cycle, so the new word sets the PC.
  assign reload = accept && (count == CNT_W'(pop_num));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_pc_q <= '0;
      tail_pc_q <= '0;
    end else if (!flush) begin
      if (reload) begin
        head_pc_q <= fetch_pc;
      end else if (pop) begin
        head_pc_q <= head_pc_q + (head_is32 ? ADDR_WIDTH'(4) : ADDR_WIDTH'(2));
      end
      // Address expected for the next fetch word.
      if (accept) tail_pc_q <= {fetch_pc[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'(4);
    end
  end

  a_fetch_contiguous: assert property (@(posedge clk) disable iff (!rst_n)
    (accept && !reload) |-> (fetch_pc == tail_pc_q));

  if_hw_queue #(
    .BUF_HW (BUF_HW)
  ) u_hw_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push_num (push_num),
    .push_hw0 (push_hw0),
    .push_hw1 (fetch_word[31:16]),
    .pop_num  (pop_num),
    .count    (count),
    .head_hw0 (head_hw0),
    .head_hw1 (head_hw1)
  );

endmodule
